// File: rtl/avalon_mm_arbiter.sv
// Three-host to one-agent Avalon-MM arbiter with grant lock while the agent stalls.
// Policy is fixed priority (h0 > h1 > h2) unless ARBITER_ROUND_ROBIN_EN is defined.
module avalon_mm_arbiter #(
    parameter int AW = 32,
    parameter int DW = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            h0_avn_read,
    input  logic            h0_avn_write,
    input  logic [AW-1:0]   h0_avn_address,
    input  logic [DW/8-1:0] h0_avn_byte_enable,
    input  logic [DW-1:0]   h0_avn_writedata,
    output logic [DW-1:0]   h0_avn_readdata,
    output logic            h0_avn_waitrequest,
    input  logic            h1_avn_read,
    input  logic            h1_avn_write,
    input  logic [AW-1:0]   h1_avn_address,
    input  logic [DW/8-1:0] h1_avn_byte_enable,
    input  logic [DW-1:0]   h1_avn_writedata,
    output logic [DW-1:0]   h1_avn_readdata,
    output logic            h1_avn_waitrequest,
    input  logic            h2_avn_read,
    input  logic            h2_avn_write,
    input  logic [AW-1:0]   h2_avn_address,
    input  logic [DW/8-1:0] h2_avn_byte_enable,
    input  logic [DW-1:0]   h2_avn_writedata,
    output logic [DW-1:0]   h2_avn_readdata,
    output logic            h2_avn_waitrequest,
    output logic            s_avn_read,
    output logic            s_avn_write,
    output logic [AW-1:0]   s_avn_address,
    output logic [DW/8-1:0] s_avn_byte_enable,
    output logic [DW-1:0]   s_avn_writedata,
    input  logic [DW-1:0]   s_avn_readdata,
    input  logic            s_avn_waitrequest,
    output logic [2:0]      grant
);

    typedef enum logic {
        S_IDLE,
        S_LOCKED
    } state_t;

    state_t     state_q, state_d;
    logic [2:0] lock_grant_q, lock_grant_d;
    logic [1:0] last_q, last_d;
    logic [2:0] req;
    logic [2:0] pick;
    logic [2:0] grant_c;

    assign req = {h2_avn_read | h2_avn_write,
                  h1_avn_read | h1_avn_write,
                  h0_avn_read | h0_avn_write};

`ifdef ARBITER_ROUND_ROBIN_EN
    // Search starts one past the last completed host and wraps.
    always_comb begin
        pick = 3'b000;
        case (last_q)
            2'd0: begin
                if (req[1])      pick = 3'b010;
                else if (req[2]) pick = 3'b100;
                else if (req[0]) pick = 3'b001;
            end
            2'd1: begin
                if (req[2])      pick = 3'b100;
                else if (req[0]) pick = 3'b001;
                else if (req[1]) pick = 3'b010;
            end
            default: begin
                if (req[0])      pick = 3'b001;
                else if (req[1]) pick = 3'b010;
                else if (req[2]) pick = 3'b100;
            end
        endcase
    end
`else
    always_comb begin
        pick = 3'b000;
        if (req[0])      pick = 3'b001;
        else if (req[1]) pick = 3'b010;
        else if (req[2]) pick = 3'b100;
    end
`endif

    always_comb begin
        state_d      = state_q;
        lock_grant_d = lock_grant_q;
        last_d       = last_q;
        grant_c      = (state_q == S_LOCKED) ? lock_grant_q : pick;
        if (state_q == S_IDLE) begin
            if ((|pick) && s_avn_waitrequest) begin
                state_d      = S_LOCKED;
                lock_grant_d = pick;
            end
        end else if (!s_avn_waitrequest) begin
            state_d      = S_IDLE;
            lock_grant_d = 3'b000;
        end
        if ((|grant_c) && !s_avn_waitrequest) begin
            last_d = grant_c[2] ? 2'd2 : (grant_c[1] ? 2'd1 : 2'd0);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            lock_grant_q <= 3'b000;
            last_q       <= 2'd2;
        end else begin
            state_q      <= state_d;
            lock_grant_q <= lock_grant_d;
            last_q       <= last_d;
        end
    end

    // Reset gates the grant so the agent sees no request in the reset cycle.
    assign grant = rst ? 3'b000 : grant_c;

    assign s_avn_read  = (grant[0] & h0_avn_read)  | (grant[1] & h1_avn_read)  | (grant[2] & h2_avn_read);
    assign s_avn_write = (grant[0] & h0_avn_write) | (grant[1] & h1_avn_write) | (grant[2] & h2_avn_write);

    assign s_avn_address     = ({AW{grant[0]}} & h0_avn_address)
                             | ({AW{grant[1]}} & h1_avn_address)
                             | ({AW{grant[2]}} & h2_avn_address);
    assign s_avn_byte_enable = ({(DW/8){grant[0]}} & h0_avn_byte_enable)
                             | ({(DW/8){grant[1]}} & h1_avn_byte_enable)
                             | ({(DW/8){grant[2]}} & h2_avn_byte_enable);
    assign s_avn_writedata   = ({DW{grant[0]}} & h0_avn_writedata)
                             | ({DW{grant[1]}} & h1_avn_writedata)
                             | ({DW{grant[2]}} & h2_avn_writedata);

    assign h0_avn_readdata = s_avn_readdata;
    assign h1_avn_readdata = s_avn_readdata;
    assign h2_avn_readdata = s_avn_readdata;

    assign h0_avn_waitrequest = grant[0] ? s_avn_waitrequest : 1'b1;
    assign h1_avn_waitrequest = grant[1] ? s_avn_waitrequest : 1'b1;
    assign h2_avn_waitrequest = grant[2] ? s_avn_waitrequest : 1'b1;

endmodule

// File: tb/tb_avalon_mm_arbiter.sv
// Self-checking bench for avalon_mm_arbiter: vector table, hand sequences, random vs model.
module tb_avalon_mm_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic [2:0]  rd, wr;
    logic [31:0] addr [3];
    logic [3:0]  be   [3];
    logic [31:0] wd   [3];
    logic [31:0] rdat [3];
    logic [2:0]  hwait;
    logic        s_read, s_write;
    logic [31:0] s_addr, s_wd, s_rdata;
    logic [3:0]  s_be;
    logic        s_wait;
    logic [2:0]  grant;

    int checks = 0;
    int errors = 0;

    int m_locked, m_lock_host, m_last;

    always #5 clk = ~clk;

    avalon_mm_arbiter #(.AW(32), .DW(32)) dut (
        .clk(clk), .rst(rst),
        .h0_avn_read(rd[0]), .h0_avn_write(wr[0]), .h0_avn_address(addr[0]),
        .h0_avn_byte_enable(be[0]), .h0_avn_writedata(wd[0]),
        .h0_avn_readdata(rdat[0]), .h0_avn_waitrequest(hwait[0]),
        .h1_avn_read(rd[1]), .h1_avn_write(wr[1]), .h1_avn_address(addr[1]),
        .h1_avn_byte_enable(be[1]), .h1_avn_writedata(wd[1]),
        .h1_avn_readdata(rdat[1]), .h1_avn_waitrequest(hwait[1]),
        .h2_avn_read(rd[2]), .h2_avn_write(wr[2]), .h2_avn_address(addr[2]),
        .h2_avn_byte_enable(be[2]), .h2_avn_writedata(wd[2]),
        .h2_avn_readdata(rdat[2]), .h2_avn_waitrequest(hwait[2]),
        .s_avn_read(s_read), .s_avn_write(s_write), .s_avn_address(s_addr),
        .s_avn_byte_enable(s_be), .s_avn_writedata(s_wd),
        .s_avn_readdata(s_rdata), .s_avn_waitrequest(s_wait),
        .grant(grant)
    );

    typedef struct {
        logic        rst;
        logic [2:0]  rd;
        logic [2:0]  wr;
        logic        sw;
        logic [31:0] srd;
        logic [2:0]  eg;
        logic        er;
        logic        ew;
        logic [31:0] ea;
        logic [3:0]  eb;
        logic [31:0] ewd;
        logic [2:0]  ewait;
    } vec_t;

    vec_t vt [12];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic set_hosts_fixed();
        addr[0] = 32'h0000_1000; be[0] = 4'h3; wd[0] = 32'hA0A0_A0A0;
        addr[1] = 32'h0000_0100; be[1] = 4'hF; wd[1] = 32'hDEAD_BEEF;
        addr[2] = 32'h0000_2000; be[2] = 4'hC; wd[2] = 32'hC2C2_C2C2;
    endtask

    task automatic drive(input logic r, input logic [2:0] rdv, input logic [2:0] wrv,
                         input logic swv, input logic [31:0] srdv);
        rst = r; rd = rdv; wr = wrv; s_wait = swv; s_rdata = srdv;
    endtask

    // Advance to the sample point before the next rising edge, then past it.
    task automatic settle();
        #3;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // Reference: search hosts in priority order; a held lock overrides the search.
    function automatic int model_winner();
        if (rst) return -1;
        if (m_locked != 0) return m_lock_host;
        for (int k = 0; k < 3; k++) begin
            int h;
`ifdef ARBITER_ROUND_ROBIN_EN
            h = (m_last + 1 + k) % 3;
`else
            h = k;
`endif
            if (rd[h] | wr[h]) return h;
        end
        return -1;
    endfunction

    task automatic model_check();
        int h;
        logic [2:0] eg, ewait;
        h = model_winner();
        eg = 3'b000;
        ewait = 3'b111;
        if (h >= 0) begin
            eg[h] = 1'b1;
            ewait[h] = s_wait;
        end
        chk("rand_grant", 32'(grant), 32'(eg));
        chk("rand_wait", 32'(hwait), 32'(ewait));
        chk("rand_read", 32'(s_read), (h >= 0) ? 32'(rd[h]) : 32'd0);
        chk("rand_write", 32'(s_write), (h >= 0) ? 32'(wr[h]) : 32'd0);
        chk("rand_addr", s_addr, (h >= 0) ? addr[h] : 32'd0);
        chk("rand_be", 32'(s_be), (h >= 0) ? 32'(be[h]) : 32'd0);
        chk("rand_wd", s_wd, (h >= 0) ? wd[h] : 32'd0);
        chk("rand_rdata", rdat[$urandom_range(0, 2)], s_rdata);
    endtask

    task automatic model_update();
        int h;
        h = model_winner();
        if (rst) begin
            m_locked = 0; m_lock_host = 0; m_last = 2;
        end else if (h >= 0) begin
            if (s_wait) begin
                m_locked = 1; m_lock_host = h;
            end else begin
                m_locked = 0; m_last = h;
            end
        end
    endtask

    initial begin
        //          rst  rd      wr      sw    srd            eg      er    ew    ea             eb     ewd            ewait
        vt[0]  = '{1'b1, 3'b111, 3'b000, 1'b0, 32'h0,         3'b000, 1'b0, 1'b0, 32'h0,         4'h0, 32'h0,         3'b111};
        vt[1]  = '{1'b0, 3'b000, 3'b000, 1'b0, 32'h0,         3'b000, 1'b0, 1'b0, 32'h0,         4'h0, 32'h0,         3'b111};
        vt[2]  = '{1'b0, 3'b000, 3'b010, 1'b0, 32'h0,         3'b010, 1'b0, 1'b1, 32'h0000_0100, 4'hF, 32'hDEAD_BEEF, 3'b101};
        vt[3]  = '{1'b0, 3'b100, 3'b000, 1'b1, 32'h0,         3'b100, 1'b1, 1'b0, 32'h0000_2000, 4'hC, 32'hC2C2_C2C2, 3'b111};
        vt[4]  = '{1'b0, 3'b101, 3'b000, 1'b1, 32'h0,         3'b100, 1'b1, 1'b0, 32'h0000_2000, 4'hC, 32'hC2C2_C2C2, 3'b111};
        vt[5]  = '{1'b0, 3'b101, 3'b000, 1'b1, 32'h0,         3'b100, 1'b1, 1'b0, 32'h0000_2000, 4'hC, 32'hC2C2_C2C2, 3'b111};
        vt[6]  = '{1'b0, 3'b101, 3'b000, 1'b0, 32'h1234_5678, 3'b100, 1'b1, 1'b0, 32'h0000_2000, 4'hC, 32'hC2C2_C2C2, 3'b011};
        vt[7]  = '{1'b0, 3'b001, 3'b000, 1'b0, 32'h0,         3'b001, 1'b1, 1'b0, 32'h0000_1000, 4'h3, 32'hA0A0_A0A0, 3'b110};
        vt[8]  = '{1'b0, 3'b100, 3'b000, 1'b1, 32'h0,         3'b100, 1'b1, 1'b0, 32'h0000_2000, 4'hC, 32'hC2C2_C2C2, 3'b111};
        vt[9]  = '{1'b1, 3'b100, 3'b000, 1'b1, 32'h0,         3'b000, 1'b0, 1'b0, 32'h0,         4'h0, 32'h0,         3'b111};
        vt[10] = '{1'b0, 3'b110, 3'b000, 1'b0, 32'h0,         3'b010, 1'b1, 1'b0, 32'h0000_0100, 4'hF, 32'hDEAD_BEEF, 3'b101};
        vt[11] = '{1'b0, 3'b100, 3'b000, 1'b0, 32'h0,         3'b100, 1'b1, 1'b0, 32'h0000_2000, 4'hC, 32'hC2C2_C2C2, 3'b011};

        set_hosts_fixed();
        drive(1'b1, 3'b000, 3'b000, 1'b0, 32'h0);
        #1;

        for (int i = 0; i < 12; i++) begin
            drive(vt[i].rst, vt[i].rd, vt[i].wr, vt[i].sw, vt[i].srd);
            settle();
            chk($sformatf("vec%0d_grant", i), 32'(grant), 32'(vt[i].eg));
            chk($sformatf("vec%0d_sread", i), 32'(s_read), 32'(vt[i].er));
            chk($sformatf("vec%0d_swrite", i), 32'(s_write), 32'(vt[i].ew));
            chk($sformatf("vec%0d_addr", i), s_addr, vt[i].ea);
            chk($sformatf("vec%0d_be", i), 32'(s_be), 32'(vt[i].eb));
            chk($sformatf("vec%0d_wd", i), s_wd, vt[i].ewd);
            chk($sformatf("vec%0d_wait", i), 32'(hwait), 32'(vt[i].ewait));
            for (int n = 0; n < 3; n++)
                chk($sformatf("vec%0d_rdata_h%0d", i, n), rdat[n], vt[i].srd);
            next_cycle();
        end

        // Contention sequences start from a fresh reset (last = host 2).
        drive(1'b1, 3'b000, 3'b000, 1'b0, 32'h0);
        next_cycle();
`ifdef ARBITER_ROUND_ROBIN_EN
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 3'b111, 3'b000, 1'b0, 32'h0);
            settle();
            chk($sformatf("rr_all_%0d", i), 32'(grant), 32'(3'b001 << i));
            next_cycle();
        end
        begin
            logic [2:0] prev;
            prev = 3'b100;
            for (int i = 0; i < 6; i++) begin
                drive(1'b0, 3'b110, 3'b000, 1'b0, 32'h0);
                settle();
                chk($sformatf("rr_alt_%0d", i), 32'(grant), (i % 2 == 0) ? 32'h2 : 32'h4);
                chk($sformatf("rr_norepeat_%0d", i), 32'(grant == prev), 32'd0);
                prev = grant;
                next_cycle();
            end
        end
`else
        drive(1'b0, 3'b111, 3'b000, 1'b0, 32'h0);
        settle();
        chk("fp_first", 32'(grant), 32'h1);
        next_cycle();
        drive(1'b0, 3'b110, 3'b000, 1'b0, 32'h0);
        settle();
        chk("fp_second", 32'(grant), 32'h2);
        next_cycle();
        drive(1'b0, 3'b100, 3'b000, 1'b0, 32'h0);
        settle();
        chk("fp_third", 32'(grant), 32'h4);
        next_cycle();
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 3'b110, 3'b000, 1'b0, 32'h0);
            settle();
            chk($sformatf("fp_sticky_%0d", i), 32'(grant), 32'h2);
            next_cycle();
        end
`endif

        // Random traffic against the reference model.
        m_locked = 0; m_lock_host = 0; m_last = 2;
        for (int c = 0; c < 3000; c++) begin
            for (int n = 0; n < 3; n++) begin
                addr[n] = $urandom;
                be[n]   = 4'($urandom_range(0, 15));
                wd[n]   = $urandom;
            end
            drive((c == 0) || ($urandom_range(0, 49) == 0),
                  3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
                  ($urandom_range(0, 2) == 0), $urandom);
            settle();
            model_check();
            @(posedge clk);
            model_update();
            #1;
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
